// File: rtl/blake2_host_driver.sv
// Host-side byte-serial transmitter for a BLAKE2 core: config, key/message blocks, hash capture.
// Optional hash-wait watchdog is built when BLAKE2_HOST_TIMEOUT_EN is defined.
module blake2_host_driver #(
  parameter int unsigned BLK_GAP   = 4,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [5:0]  kk_i,
  input  logic [5:0]  nn_i,
  input  logic [63:0] ll_i,
  input  logic        msg_v_i,
  input  logic [7:0]  msg_i,
  output logic        msg_ready_o,
  output logic        valid_o,
  output logic [1:0]  cmd_o,
  output logic [7:0]  data_o,
  input  logic        ready_v_i,
  input  logic        hash_v_i,
  input  logic [7:0]  hash_i,
  output logic        busy_o,
  output logic        hash_byte_v_o,
  output logic [7:0]  hash_byte_o,
  output logic [5:0]  hash_idx_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [2:0] {S_IDLE, S_CONF, S_WAIT_RDY, S_BLOCK, S_GAP, S_HASH} state_t;
  typedef enum logic [1:0] {CMD_CONF, CMD_START, CMD_DATA, CMD_LAST} cmd_t;

  state_t      r_state, w_next;
  logic [5:0]  r_kk, r_nn, r_b, r_idx;
  logic [63:0] r_ll, r_rem, r_blk_left;
  logic        r_single, r_first, r_keyblk;
  logic [15:0] r_cnt;

  logic        r_valid, r_hv, r_done, r_err;
  logic [1:0]  r_cmd;
  logic [7:0]  r_data, r_hb;
  logic [5:0]  r_hidx;

  logic        w_bad, w_payload, w_take, w_emit;
  logic [63:0] w_nblk;
  logic [2:0]  w_ll_sel;
  cmd_t        w_blk_cmd;
  logic        w_valid, w_hv, w_done, w_err;
  logic [1:0]  w_cmd;
  logic [7:0]  w_data;

`ifdef BLAKE2_HOST_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_to;
`endif

  assign w_bad    = (kk_i > 6'd32) || (nn_i == 6'd0) || (nn_i > 6'd32);
  assign w_nblk   = 64'(kk_i != 6'd0) + (ll_i >> 6) + 64'(|ll_i[5:0]);
  assign w_ll_sel = 3'(r_cnt[3:0] - 4'd2);

  // Key block: payload while b < kk. Message blocks: payload until the remaining count hits 0.
  assign w_payload = r_keyblk ? (r_b < r_kk) : (r_rem != '0);
  assign w_take    = (r_state == S_BLOCK) && w_payload && msg_v_i;
  assign w_emit    = (r_state == S_BLOCK) && (!w_payload || msg_v_i);

  always_comb begin
    if (r_single)                w_blk_cmd = (r_b == 6'd63) ? CMD_LAST : CMD_START;
    else if (r_first)            w_blk_cmd = CMD_START;
    else if (r_blk_left == 64'd1) w_blk_cmd = CMD_LAST;
    else                         w_blk_cmd = CMD_DATA;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_valid = 1'b0;
    w_cmd   = CMD_CONF;
    w_data  = '0;
    w_hv    = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (w_bad) w_err  = 1'b1;
          else       w_next = S_CONF;
        end
      end
      S_CONF: begin
        w_valid = 1'b1;
        case (r_cnt[3:0])
          4'd0:    w_data = {2'b00, r_kk};
          4'd1:    w_data = {2'b00, r_nn};
          default: w_data = 8'(r_ll >> {w_ll_sel, 3'b000});
        endcase
        if (r_cnt[3:0] == 4'd9) w_next = S_WAIT_RDY;
      end
      S_WAIT_RDY: if (ready_v_i) w_next = S_BLOCK;
      S_BLOCK: begin
        if (w_emit) begin
          w_valid = 1'b1;
          w_cmd   = w_blk_cmd;
          w_data  = w_payload ? msg_i : 8'h00;
          if (r_b == 6'd63) w_next = (r_blk_left == 64'd1) ? S_HASH : S_GAP;
        end
      end
      S_GAP: if (32'(r_cnt) + 32'd1 >= BLK_GAP) w_next = S_WAIT_RDY;
      S_HASH: begin
        if (hash_v_i) begin
          w_hv = 1'b1;
          if (r_idx == r_nn - 6'd1) begin
            w_done = 1'b1;
            w_next = S_IDLE;
          end
        end
`ifdef BLAKE2_HOST_TIMEOUT_EN
        else if (r_to == '1) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kk <= '0; r_nn <= '0; r_ll <= '0; r_rem <= '0; r_blk_left <= '0;
      r_single <= 1'b0; r_first <= 1'b0; r_keyblk <= 1'b0;
      r_b <= '0; r_idx <= '0; r_cnt <= '0;
      r_valid <= 1'b0; r_cmd <= '0; r_data <= '0;
      r_hv <= 1'b0; r_hb <= '0; r_hidx <= '0; r_done <= 1'b0; r_err <= 1'b0;
    end else begin
      r_valid <= w_valid;
      r_cmd   <= w_cmd;
      r_data  <= w_data;
      r_hv    <= w_hv;
      r_done  <= w_done;
      r_err   <= w_err;
      if (w_hv) begin
        r_hb   <= hash_i;
        r_hidx <= r_idx;
      end
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (start_i && !w_bad) begin
            r_kk       <= kk_i;
            r_nn       <= nn_i;
            r_ll       <= ll_i;
            r_rem      <= ll_i;
            r_blk_left <= (w_nblk == '0) ? 64'd1 : w_nblk;
            r_single   <= (w_nblk <= 64'd1);
            r_first    <= 1'b1;
            r_keyblk   <= (kk_i != 6'd0);
          end
        end
        S_CONF:     r_cnt <= (r_cnt[3:0] == 4'd9) ? '0 : r_cnt + 16'd1;
        S_WAIT_RDY: begin
          r_b   <= '0;
          r_cnt <= '0;
        end
        S_BLOCK: begin
          if (w_take && !r_keyblk) r_rem <= r_rem - 64'd1;
          if (w_emit) begin
            r_b <= r_b + 6'd1;
            if (r_b == 6'd63) begin
              r_blk_left <= r_blk_left - 64'd1;
              r_first    <= 1'b0;
              r_keyblk   <= 1'b0;
            end
          end
        end
        S_GAP:  r_cnt <= r_cnt + 16'd1;
        S_HASH: if (hash_v_i) r_idx <= r_idx + 6'd1;
        default: ;
      endcase
    end
  end

`ifdef BLAKE2_HOST_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             r_to <= '0;
    else if (r_state == S_HASH && !hash_v_i) r_to <= r_to + 1'b1;
    else                                   r_to <= '0;
  end
`endif

  assign msg_ready_o   = (r_state == S_BLOCK) && w_payload;
  assign busy_o        = (r_state != S_IDLE);
  assign valid_o       = r_valid;
  assign cmd_o         = r_cmd;
  assign data_o        = r_data;
  assign hash_byte_v_o = r_hv;
  assign hash_byte_o   = r_hb;
  assign hash_idx_o    = r_hidx;
  assign done_o        = r_done;
  assign error_o       = r_err;

endmodule

// File: tb/tb_blake2_host_driver.sv
// Directed bench for blake2_host_driver: job table with a spec-level stream model, plus a mid-block reset sequence.
module tb_blake2_host_driver;
  localparam int unsigned BLK_GAP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [5:0]  kk_i = '0;
  logic [5:0]  nn_i = '0;
  logic [63:0] ll_i = '0;
  logic        msg_v_i = 1'b0;
  logic [7:0]  msg_i = '0;
  logic        ready_v_i = 1'b1;
  logic        hash_v_i = 1'b0;
  logic [7:0]  hash_i = '0;
  logic        msg_ready_o, valid_o, busy_o, hash_byte_v_o, done_o, error_o;
  logic [1:0]  cmd_o;
  logic [7:0]  data_o, hash_byte_o;
  logic [5:0]  hash_idx_o;

  blake2_host_driver #(.BLK_GAP(BLK_GAP), .TIMEOUT_W(16)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i), .ll_i(ll_i),
    .msg_v_i(msg_v_i), .msg_i(msg_i), .msg_ready_o(msg_ready_o),
    .valid_o(valid_o), .cmd_o(cmd_o), .data_o(data_o), .ready_v_i(ready_v_i),
    .hash_v_i(hash_v_i), .hash_i(hash_i), .busy_o(busy_o),
    .hash_byte_v_o(hash_byte_v_o), .hash_byte_o(hash_byte_o), .hash_idx_o(hash_idx_o),
    .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  kk;
    logic [5:0]  nn;
    logic [63:0] ll;
    logic [7:0]  seed;
    bit          tog;
    int          rdy_low;
    bit          exp_err;
    int          exp_nblk;
    int          exp_gap;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [7:0] pay [0:255];
  int  pay_len = 0;
  bit  feed_en = 1'b0;
  bit  tog = 1'b0;
  int  rdy_low_cfg = 0;
  bit  clr_req = 1'b0;

  logic [9:0] cap_q[$];
  int         cap_t[$];
  logic [5:0] hidx_q[$];
  logic [7:0] hdat_q[$];
  int cyc = 0, err_cyc = 0, busy_cyc = 0, rdy_viol = 0, done_cnt = 0, done_idx = 0, rdy_start = -1;
  bit done_with_byte = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int kk, int nn, longint ll, int seed, bit tg, int rl, bit er, int nb, int gp);
    vec_t v;
    v.kk = 6'(kk); v.nn = 6'(nn); v.ll = 64'(ll); v.seed = 8'(seed);
    v.tog = tg; v.rdy_low = rl; v.exp_err = er; v.exp_nblk = nb; v.exp_gap = gp;
    return v;
  endfunction

  // Output monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (clr_req) begin
      cap_q.delete(); cap_t.delete(); hidx_q.delete(); hdat_q.delete();
      err_cyc = 0; busy_cyc = 0; rdy_viol = 0; done_cnt = 0; done_idx = 0;
      rdy_start = -1; done_with_byte = 1'b0;
    end else begin
      if (valid_o) begin
        cap_q.push_back({cmd_o, data_o});
        cap_t.push_back(cyc);
        if (!ready_v_i) rdy_viol++;
        if (rdy_low_cfg > 0 && cap_q.size() == 74) rdy_start = cyc;
      end
      if (error_o) err_cyc++;
      if (busy_o) busy_cyc++;
      if (hash_byte_v_o) begin
        hidx_q.push_back(hash_idx_o);
        hdat_q.push_back(hash_byte_o);
      end
      if (done_o) begin
        done_cnt++;
        done_idx = int'(hash_idx_o);
        done_with_byte = hash_byte_v_o;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    ready_v_i = !(rdy_start >= 0 && cyc >= rdy_start && cyc < rdy_start + rdy_low_cfg);
  end

  // Payload source; tog=1 offers a byte only on alternate cycles.
  initial begin
    bit took, phase;
    int pay_idx;
    pay_idx = 0; phase = 1'b0;
    forever begin
      @(negedge clk);
      took = msg_v_i && msg_ready_o;
      @(posedge clk); #1;
      if (!feed_en) begin
        pay_idx = 0; phase = 1'b0; msg_v_i = 1'b0; msg_i = '0;
      end else begin
        if (took) pay_idx++;
        phase = !phase;
        if (pay_idx < pay_len && (!tog || phase)) begin
          msg_v_i = 1'b1; msg_i = pay[pay_idx];
        end else begin
          msg_v_i = 1'b0; msg_i = '0;
        end
      end
    end
  end

  task automatic load(input vec_t v);
    pay_len = int'(v.kk) + int'(v.ll);
    for (int k = 0; k < 256; k++) pay[k] = v.seed + 8'(k * 17);
    tog = v.tog;
    rdy_low_cfg = v.rdy_low;
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    feed_en = 1'b1;
    kk_i = v.kk; nn_i = v.nn; ll_i = v.ll;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input int id);
    logic [9:0] exp_q[$];
    int bad;
    load(v);
    if (v.exp_err) begin
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("job%0d_error_pulse", id), 64'(err_cyc), 64'd1);
      check($sformatf("job%0d_no_valid", id), 64'(cap_q.size()), 64'd0);
      check($sformatf("job%0d_not_busy", id), 64'(busy_cyc), 64'd0);
    end else begin
      exp_q.push_back({2'd0, 2'b00, v.kk});
      exp_q.push_back({2'd0, 2'b00, v.nn});
      for (int i = 0; i < 8; i++) exp_q.push_back({2'd0, 8'(v.ll >> (8 * i))});
      for (int blk = 0; blk < v.exp_nblk; blk++) begin
        for (int b = 0; b < 64; b++) begin
          logic [7:0] d;
          logic [1:0] c;
          int moff;
          if (v.kk != 0 && blk == 0) d = (b < int'(v.kk)) ? pay[b] : 8'h00;
          else begin
            moff = (blk - ((v.kk != 0) ? 1 : 0)) * 64 + b;
            d = (64'(moff) < v.ll) ? pay[int'(v.kk) + moff] : 8'h00;
          end
          if (v.exp_nblk == 1)             c = (b == 63) ? 2'd3 : 2'd1;
          else if (blk == 0)               c = 2'd1;
          else if (blk == v.exp_nblk - 1)  c = 2'd3;
          else                             c = 2'd2;
          exp_q.push_back({c, d});
        end
      end
      for (int c = 0; c < 4000 && cap_q.size() < exp_q.size(); c++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < int'(v.nn) + 2; i++) begin
        hash_v_i = 1'b1; hash_i = 8'h50 + 8'(i);
        @(posedge clk); #1;
      end
      hash_v_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("job%0d_stream_len", id), 64'(cap_q.size()), 64'(exp_q.size()));
      bad = -1;
      for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
        if (bad < 0 && cap_q[i] !== exp_q[i]) bad = i;
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL job%0d_stream byte %0d: got cmd/data %h expected %h", id, bad, cap_q[bad], exp_q[bad]);
      end
      check($sformatf("job%0d_hash_count", id), 64'(hidx_q.size()), 64'(v.nn));
      bad = -1;
      for (int i = 0; i < hidx_q.size(); i++)
        if (bad < 0 && (hidx_q[i] !== 6'(i) || hdat_q[i] !== 8'h50 + 8'(i))) bad = i;
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL job%0d_hash entry %0d: got idx %0d byte %h expected idx %0d byte %h",
                 id, bad, hidx_q[bad], hdat_q[bad], bad, 8'h50 + 8'(bad));
      end
      check($sformatf("job%0d_done_count", id), 64'(done_cnt), 64'd1);
      check($sformatf("job%0d_done_idx", id), 64'(done_idx), 64'(int'(v.nn) - 1));
      check($sformatf("job%0d_done_with_byte", id), 64'(done_with_byte), 64'd1);
      check($sformatf("job%0d_idle_after", id), 64'(busy_o), 64'd0);
      check($sformatf("job%0d_no_error", id), 64'(err_cyc), 64'd0);
      check($sformatf("job%0d_no_valid_while_not_ready", id), 64'(rdy_viol), 64'd0);
      if (v.exp_gap > 0 && cap_t.size() > 74)
        check($sformatf("job%0d_block_gap", id), 64'(cap_t[74] - cap_t[73]), 64'(v.exp_gap));
    end
    feed_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs[10];
    // Block-boundary gap with ready held high: BLK_GAP idle cycles plus one WAIT_RDY cycle, plus one.
    vecs[0] = mk(0,  32, 3,   'hAA, 1'b0, 0,  1'b0, 1, 0);
    vecs[1] = mk(16, 16, 64,  'h10, 1'b0, 0,  1'b0, 2, int'(BLK_GAP) + 2);
    vecs[2] = mk(0,  8,  130, 'h20, 1'b0, 20, 1'b0, 3, 0);
    vecs[3] = mk(0,  4,  70,  'h40, 1'b1, 0,  1'b0, 2, 0);
    vecs[4] = mk(0,  0,  5,   'h00, 1'b0, 0,  1'b1, 0, 0);
    vecs[5] = mk(33, 4,  5,   'h00, 1'b0, 0,  1'b1, 0, 0);
    vecs[6] = mk(5,  1,  0,   'h60, 1'b0, 0,  1'b0, 1, 0);
    vecs[7] = mk(0,  32, 0,   'h00, 1'b0, 0,  1'b0, 1, 0);
    vecs[8] = mk(32, 33, 1,   'h00, 1'b0, 0,  1'b1, 0, 0);
    vecs[9] = mk(32, 32, 65,  'h70, 1'b1, 0,  1'b0, 3, 0);

    #12;
    check("reset_outputs", 64'({valid_o, cmd_o, data_o, busy_o, msg_ready_o, hash_byte_v_o,
                                hash_byte_o, hash_idx_o, done_o, error_o}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) run_job(vecs[i], i);

    // Reset in the middle of block byte 20.
    load(mk(0, 4, 100, 'h30, 1'b0, 0, 1'b0, 2, 0));
    for (int c = 0; c < 400 && cap_q.size() < 31; c++) @(posedge clk);
    #1;
    check("rst_reached_byte20", 64'(cap_q.size() >= 31), 64'd1);
    check("rst_busy_before", 64'(busy_o), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_outputs", 64'({valid_o, cmd_o, data_o, busy_o, msg_ready_o, hash_byte_v_o,
                                    hash_byte_o, hash_idx_o, done_o, error_o}), 64'd0);
    feed_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_job(vecs[0], 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
